// File: rtl/hkspi_responder_if.sv
// ---------------------------------------------------------------------------
// hkspi_responder_if
//
// Register-file bus between the housekeeping SPI responder and the
// housekeeping register file.
//   reg_addr   8  register address
//   reg_wdata  8  write data, valid while reg_we is high
//   reg_we     1  one-cycle write strobe
//   reg_re     1  one-cycle read strobe
//   reg_rdata  8  read data, valid the cycle after reg_re
// Modports:
//   master  the SPI responder (issues strobes, consumes read data)
//   slave   the register file (consumes strobes, returns read data)
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

interface hkspi_responder_if;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_we;
  logic       reg_re;
  logic [7:0] reg_rdata;

  modport master (
    output reg_addr,
    output reg_wdata,
    output reg_we,
    output reg_re,
    input  reg_rdata
  );

  modport slave (
    input  reg_addr,
    input  reg_wdata,
    input  reg_we,
    input  reg_re,
    output reg_rdata
  );
endinterface

// File: rtl/hkspi_responder.sv
// ---------------------------------------------------------------------------
// hkspi_responder
//
// Housekeeping SPI target. Decodes command byte / address byte / data stream
// and turns it into single-cycle read and write strobes on the register bus.
// The SPI pins are oversampled in the clock domain; nothing runs on SCK.
//
// Ports:
//   clock    system clock, all state changes on its rising edge
//   resetb   synchronous active-low reset
//   sck      SPI clock (mode 0), asynchronous
//   csb      SPI chip select, active low, asynchronous
//   sdi      SPI data in, MSB first
//   sdo      SPI data out, MSB first
//   sdo_oe   high while read data is being shifted out
//   bus      register-file bus (master side)
//
// Parameter:
//   CLK_PER_SCK_MIN  minimum clock cycles per SCK high/low phase; the first
//                    read bit is only ready in time when the low phase is at
//                    least this long. Not used by the logic itself.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module hkspi_responder #(
  parameter int CLK_PER_SCK_MIN = 4
) (
  input  logic              clock,
  input  logic              resetb,
  input  logic              sck,
  input  logic              csb,
  input  logic              sdi,
  output logic              sdo,
  output logic              sdo_oe,
  hkspi_responder_if.master bus
);

  // Read data is loaded up to 4 cycles after the detected rise, so a shorter
  // SCK low phase cannot present the first read bit correctly.
  if (CLK_PER_SCK_MIN < 4) begin : g_sck_min_check
    $error("hkspi_responder: CLK_PER_SCK_MIN must be at least 4");
  end

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    DATA,
    DONE
  } state_t;

  state_t state_q, state_d;

  // Synchronizers; sck_prev is the edge-detect history flop.
  logic sck_s1, sck_s2, sck_prev;
  logic csb_s1, csb_s2;
  logic sdi_s1, sdi_s2;

  logic       sck_rise, sck_fall;
  logic       shifting;
  logic       byte_done;
  logic       last_byte;
  logic [7:0] byte_in;

  logic [2:0] bit_cnt;
  logic [2:0] byte_cnt;
  logic [6:0] shift_in;
  logic [7:0] shift_out;

  logic cmd_write;
  logic cmd_read;
  logic cnt_mode;   // non-zero count field: stop after byte_cnt data bytes
  logic inc_pend;   // address increment deferred behind a write strobe
  logic re_pend;    // read strobe deferred behind a write strobe
  logic re_dly;     // reg_re delayed one cycle: reg_rdata is valid now

  assign sck_rise  = sck_s2 & ~sck_prev;
  assign sck_fall  = ~sck_s2 & sck_prev;
  assign shifting  = (state_q == CMD) || (state_q == ADDR) || (state_q == DATA);
  assign byte_in   = {shift_in, sdi_s2};
  assign byte_done = shifting && sck_rise && (bit_cnt == 3'd7);
  assign last_byte = (state_q == DATA) && byte_done && cnt_mode && (byte_cnt == 3'd1);

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (!resetb) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: state_d gets a default before the case so every path assigns it
    // and no latch is inferred.
    state_d = state_q;
    unique case (state_q)
      IDLE: if (!csb_s2) state_d = CMD;
      CMD:  if (byte_done) state_d = (byte_in[7] | byte_in[6]) ? ADDR : DONE;
      ADDR: if (byte_done) state_d = DATA;
      DATA: if (last_byte) state_d = DONE;
      DONE: state_d = DONE;
      default: state_d = IDLE;
    endcase
    // Chip select released: abandon whatever was in progress.
    if (csb_s2) state_d = IDLE;
  end

  // -------------------------------------------------------------------------
  // Datapath: synchronizers, shifters, strobes
  // -------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (!resetb) begin
      // NOTE: the synchronizers are reset too, with csb held inactive, so the
      // FSM cannot see a phantom chip-select right after reset.
      sck_s1        <= 1'b0;
      sck_s2        <= 1'b0;
      sck_prev      <= 1'b0;
      csb_s1        <= 1'b1;
      csb_s2        <= 1'b1;
      sdi_s1        <= 1'b0;
      sdi_s2        <= 1'b0;
      bit_cnt       <= '0;
      byte_cnt      <= '0;
      shift_in      <= '0;
      shift_out     <= '0;
      cmd_write     <= 1'b0;
      cmd_read      <= 1'b0;
      cnt_mode      <= 1'b0;
      inc_pend      <= 1'b0;
      re_pend       <= 1'b0;
      re_dly        <= 1'b0;
      sdo           <= 1'b0;
      sdo_oe        <= 1'b0;
      bus.reg_addr  <= '0;
      bus.reg_wdata <= '0;
      bus.reg_we    <= 1'b0;
      bus.reg_re    <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only; later
      // assignments in this block deliberately override the strobe defaults.
      sck_s1   <= sck;
      sck_s2   <= sck_s1;
      sck_prev <= sck_s2;
      csb_s1   <= csb;
      csb_s2   <= csb_s1;
      sdi_s1   <= sdi;
      sdi_s2   <= sdi_s1;

      bus.reg_we <= 1'b0;
      bus.reg_re <= 1'b0;
      re_dly     <= bus.reg_re;

      // Bit assembly; a partial byte is dropped when csb rises.
      if (!shifting || csb_s2) begin
        bit_cnt  <= '0;
        shift_in <= '0;
      end else if (sck_rise) begin
        shift_in <= byte_in[6:0];
        bit_cnt  <= bit_cnt + 3'd1;
      end

      // Second half of a write-then-read: advance address after the write.
      if (inc_pend) begin
        bus.reg_addr <= bus.reg_addr + 8'd1;
        bus.reg_re   <= re_pend;
        inc_pend     <= 1'b0;
        re_pend      <= 1'b0;
      end

      if (byte_done) begin
        unique case (state_q)
          CMD: begin
            cmd_write <= byte_in[7];
            cmd_read  <= byte_in[6];
            byte_cnt  <= byte_in[5:3];
            cnt_mode  <= |byte_in[5:3];
          end
          ADDR: begin
            bus.reg_addr <= byte_in;
            bus.reg_re   <= cmd_read;
          end
          DATA: begin
            if (cmd_write) begin
              bus.reg_wdata <= byte_in;
              bus.reg_we    <= 1'b1;
              inc_pend      <= 1'b1;
              re_pend       <= cmd_read & ~last_byte;
            end else begin
              bus.reg_addr <= bus.reg_addr + 8'd1;
              bus.reg_re   <= cmd_read & ~last_byte;
            end
            if (cnt_mode) byte_cnt <= byte_cnt - 3'd1;
          end
          default: ;
        endcase
      end

      // Mode 0 output: next bit appears after each falling edge.
      if (sck_fall && (state_q == DATA)) begin
        sdo       <= shift_out[7];
        shift_out <= {shift_out[6:0], 1'b0};
      end

      // Capture read data; only meaningful while still streaming data.
      if (re_dly && (state_q == DATA)) begin
        shift_out <= bus.reg_rdata;
        sdo_oe    <= 1'b1;
      end
      if (state_d != DATA) sdo_oe <= 1'b0;
    end
  end

endmodule

// File: doc/hkspi_responder.md
# hkspi_responder

Synthesizable SPI target implementing the housekeeping SPI command protocol (command byte, address byte, data stream) and translating it into single-cycle register read/write strobes for the housekeeping register file. It sits inside the management area behind the `mprj_io[4:1]` pads (SCK, CSB, SDI, SDO) and answers the same transactions an external host issues over the housekeeping SPI. SPI inputs are oversampled in the `clock` domain; there is no SCK-domain logic.

## Interface
- `CLK_PER_SCK_MIN` (default 4): minimum number of `clock` cycles in each SCK high and each SCK low phase. Documentation and assertion bound only; not used in the logic.
- `clock`  in  1  system clock; all state changes on its rising edge.
- `resetb`  in  1  synchronous, active-low reset.
- `sck`  in  1  SPI clock, asynchronous to `clock`, mode 0.
- `csb`  in  1  SPI chip select, active low, asynchronous.
- `sdi`  in  1  SPI data in, MSB first.
- `sdo`  out  1  SPI data out, MSB first.
- `sdo_oe`  out  1  high while read data is being shifted out.
- `reg_addr`  out  8  register address.
- `reg_wdata`  out  8  write data.
- `reg_we`  out  1  one-cycle write strobe.
- `reg_re`  out  1  one-cycle read strobe.
- `reg_rdata`  in  8  read data, valid the cycle after `reg_re`.

## Operation
- Synchronization: 2-flop synchronizers on `sck`, `csb` and `sdi`. A third `sck` flop provides edge detection: rise = sync & ~prev, fall = ~sync & prev.
- States:
  - IDLE: waits for synced `csb` low, then goes to CMD.
  - CMD: shifts 8 bits.
  - ADDR: shifts 8 bits.
  - DATA: streams data bytes.
  - DONE: ignores `sck` until `csb` rises.
- Synced `csb` high in any state returns to IDLE on the next cycle. The bit counter clears and any partial byte is discarded with no strobe.
- Command byte fields:
  - bit7 = write, bit6 = read, bits[5:3] = count (0 means stream until `csb` rises; otherwise 1–7 bytes), bits[2:0] ignored.
  - Both bit7 and bit6 zero is a no-op command: CMD goes to DONE.
  - 0xC0-class commands do read and write on the same byte.
- Bit shifting: each SCK rise shifts synced `sdi` into `shift_in` at the LSB.
- On the 8th rise of the address byte:
  - Load `reg_addr`.
  - If read is set, pulse `reg_re` on the next cycle, capture `reg_rdata` one cycle later into `shift_out`, and set `sdo_oe`.
- Read data output: on each SCK fall in DATA, `sdo` takes `shift_out[7]`, then `shift_out` shifts left. The MSB is therefore presented after the falling edge that ends the address byte.
- On the 8th rise of each data byte:
  - If write is set, drive `reg_wdata` from the assembled byte and pulse `reg_we` with the current `reg_addr`, 1 cycle after the rise is detected.
  - Then `reg_addr` increments modulo 256 (0xFF wraps to 0x00).
  - If read is set, issue `reg_re` for the new address on the next cycle and reload `shift_out`.
- Byte counting: a byte counter decrements per completed data byte. When it reaches 0 in count mode, go to DONE with `sdo_oe` low. Streaming mode never goes to DONE.
- `reg_we` and `reg_re` are never asserted in the same cycle. When both apply, `reg_we` goes first and `reg_re` one cycle later.

## Timing
- Reset values:
  - `sdo` = 0, `sdo_oe` = 0, `reg_addr` = 0x00, `reg_wdata` = 0x00, `reg_we` = 0, `reg_re` = 0.
  - State = IDLE, counters = 0.
  - Reset mid-transaction aborts with no strobe.
- Input-to-edge latency: 3 `clock` cycles from a pin transition to the detected edge.
- Strobe latency: `reg_we` and `reg_re` follow the detected 8th rise by 1 cycle (`reg_re` by 2 when it follows a `reg_we`).
- `shift_out` is loaded by cycle 4 after the detected rise. This requires the SCK low phase to be at least `CLK_PER_SCK_MIN` cycles for the first read bit to be valid at the fall.
- `sdo` is valid 4 cycles after the pin-level SCK fall and held until the next fall.
- A `csb` rise coincident with the 8th SCK rise: the byte completes and its strobe fires. IDLE takes effect on the following cycle.

## Test plan
- Single read: bench at `clock` 50 MHz, SCK period 200 ns. Send 0x40, 0x03 with the model returning 0x10 at address 3 → `reg_re` with `reg_addr` = 0x03; 0x10 is shifted out on `sdo` MSB first.
- Stream write: send 0x80, 0x07, 0x01; then 0x80, 0x07, 0x00 → exactly two `reg_we` at address 0x07, with data 0x01 then 0x00.
- Stream read of 19 bytes from address 0x00, model returning 00 04 56 10 00 00 00 00 02 01 00 00 00 FF EF FF 03 12 04 → `reg_re` addresses 0x00..0x12 in order, with matching bytes on `sdo`.
- Count mode: send 0x50 (read, count 2), address 0x08, then 3 data bytes clocked → 2 `reg_re` (0x08, 0x09); `sdo_oe` = 0 during the third byte.
- Wrap and abort: send 0x80, 0xFF, 0xAA, 0xBB → writes to 0xFF then 0x00. Then send 0x80, 0x10, 4 bits, `csb` high → no `reg_we`.
- Reset: assert `resetb` low mid-data byte → all outputs at reset values; the next transaction 0x40, 0x03 behaves exactly as the single-read scenario.
